// File: rtl/sat_engine_ctrl.sv
// rtl/sat_engine_ctrl.sv - sequencing controller for one Sat Engine bin
// Drives decide/imply/analyze/backtrack requests to the state list and reports run results.
module sat_engine_ctrl #(
  parameter int WIDTH_LVL     = 16,
  parameter int WIDTH_BIN_ID  = 10,
  parameter int WIDTH_CNT     = 16,
  parameter int MAX_CONFLICTS = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [WIDTH_BIN_ID-1:0] cur_bin_num_i,
  input  logic [WIDTH_LVL-1:0]    base_lvl_i,
  input  logic [WIDTH_LVL-1:0]    load_lvl_i,
  output logic                    load_lvl_en_o,
  output logic                    base_lvl_en_o,
  output logic [WIDTH_LVL-1:0]    load_lvl_o,
  output logic [WIDTH_LVL-1:0]    base_lvl_o,
  output logic                    start_decision_o,
  input  logic                    done_decision_i,
  input  logic                    all_assigned_i,
  input  logic [WIDTH_LVL-1:0]    cur_lvl_i,
  output logic                    apply_imply_o,
  input  logic                    done_imply_i,
  input  logic                    find_conflict_i,
  output logic                    apply_analyze_o,
  input  logic                    add_learntc_en_i,
  input  logic                    done_analyze_i,
  input  logic [WIDTH_BIN_ID-1:0] bkt_bin_i,
  input  logic [WIDTH_LVL-1:0]    bkt_lvl_i,
  output logic                    apply_bkt_cur_bin_o,
  input  logic                    done_bkt_cur_bin_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [1:0]              result_o,
  output logic [WIDTH_BIN_ID-1:0] bkt_bin_o,
  output logic [WIDTH_LVL-1:0]    bkt_lvl_o,
  output logic [WIDTH_CNT-1:0]    num_decisions_o,
  output logic [WIDTH_CNT-1:0]    num_conflicts_o,
  output logic [WIDTH_CNT-1:0]    num_learnt_o
);

  localparam logic [1:0] RES_SAT       = 2'd0;
  localparam logic [1:0] RES_UNSAT     = 2'd1;
  localparam logic [1:0] RES_BKT_OTHER = 2'd2;
  localparam logic [1:0] RES_ABORT     = 2'd3;

  // Budget counter is separate from the reported counter so the abort
  // decision is unaffected by the statistics saturating.
  localparam int              CB_W   = $clog2(MAX_CONFLICTS + 2);
  localparam logic [CB_W-1:0] CB_MAX = CB_W'(MAX_CONFLICTS);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_IMPLY, S_DECIDE, S_WAIT_DEC,
    S_ANALYZE, S_ANA_REL, S_BKT, S_DONE
  } state_t;

  state_t                    state, state_nxt;
  logic [WIDTH_BIN_ID-1:0]   cur_bin;
  logic [CB_W-1:0]           conf_budget;
  logic                      capture, cap_bkt, set_res, inc_conf, inc_dec;
  logic                      inc_learnt;
  logic [1:0]                res_nxt;

  function automatic logic [WIDTH_CNT-1:0] sat_inc(input logic [WIDTH_CNT-1:0] v);
    return (&v) ? v : v + WIDTH_CNT'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    cap_bkt   = 1'b0;
    set_res   = 1'b0;
    res_nxt   = RES_SAT;
    inc_conf  = 1'b0;
    inc_dec   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          capture   = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD:   state_nxt = S_IMPLY;
      S_IMPLY: begin
        if (done_imply_i) begin
          if (!find_conflict_i) begin
            state_nxt = S_DECIDE;
          end else begin
            inc_conf = 1'b1;
            // A conflict at or below level 0 in the root bin is a proof of UNSAT.
            if (cur_lvl_i <= base_lvl_o && base_lvl_o == '0) begin
              set_res   = 1'b1;
              res_nxt   = RES_UNSAT;
              state_nxt = S_DONE;
            end else if (conf_budget >= CB_MAX) begin
              set_res   = 1'b1;
              res_nxt   = RES_ABORT;
              state_nxt = S_DONE;
            end else begin
              state_nxt = S_ANALYZE;
            end
          end
        end
      end
      S_DECIDE: state_nxt = S_WAIT_DEC;
      S_WAIT_DEC: begin
        if (done_decision_i) begin
          if (all_assigned_i) begin
            set_res   = 1'b1;
            res_nxt   = RES_SAT;
            state_nxt = S_DONE;
          end else begin
            inc_dec   = 1'b1;
            state_nxt = S_IMPLY;
          end
        end
      end
      S_ANALYZE: begin
        if (done_analyze_i) begin
          cap_bkt   = 1'b1;
          state_nxt = S_ANA_REL;
        end
      end
      S_ANA_REL: begin
        if (bkt_bin_o == cur_bin) begin
          state_nxt = S_BKT;
        end else begin
          set_res   = 1'b1;
          res_nxt   = RES_BKT_OTHER;
          state_nxt = S_DONE;
        end
      end
      S_BKT: begin
        if (done_bkt_cur_bin_i) state_nxt = S_IMPLY;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign inc_learnt = (state == S_ANALYZE) && add_learntc_en_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_bin         <= '0;
      load_lvl_o      <= '0;
      base_lvl_o      <= '0;
      result_o        <= RES_SAT;
      bkt_bin_o       <= '0;
      bkt_lvl_o       <= '0;
      num_decisions_o <= '0;
      num_conflicts_o <= '0;
      num_learnt_o    <= '0;
      conf_budget     <= '0;
    end else if (capture) begin
      cur_bin         <= cur_bin_num_i;
      load_lvl_o      <= load_lvl_i;
      base_lvl_o      <= base_lvl_i;
      result_o        <= RES_SAT;
      bkt_bin_o       <= '0;
      bkt_lvl_o       <= '0;
      num_decisions_o <= '0;
      num_conflicts_o <= '0;
      num_learnt_o    <= '0;
      conf_budget     <= '0;
    end else begin
      if (set_res) result_o <= res_nxt;
      if (cap_bkt) begin
        bkt_bin_o <= bkt_bin_i;
        bkt_lvl_o <= bkt_lvl_i;
      end
      if (inc_conf) begin
        num_conflicts_o <= sat_inc(num_conflicts_o);
        if (conf_budget < CB_MAX) conf_budget <= conf_budget + CB_W'(1);
      end
      if (inc_dec)    num_decisions_o <= sat_inc(num_decisions_o);
      if (inc_learnt) num_learnt_o    <= sat_inc(num_learnt_o);
    end
  end

  assign load_lvl_en_o       = (state == S_LOAD);
  assign base_lvl_en_o       = (state == S_LOAD);
  assign apply_imply_o       = (state == S_IMPLY);
  assign start_decision_o    = (state == S_DECIDE);
  assign apply_analyze_o     = (state == S_ANALYZE);
  assign apply_bkt_cur_bin_o = (state == S_BKT);
  assign done_o              = (state == S_DONE);
  assign busy_o              = (state != S_IDLE);

endmodule

// File: tb/tb_sat_engine_ctrl.sv
// tb/tb_sat_engine_ctrl.sv - self-checking bench for sat_engine_ctrl
module tb_sat_engine_ctrl;

  localparam int LW   = 16;
  localparam int BW   = 10;
  localparam int CW   = 16;
  localparam int MAXC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [BW-1:0] cur_bin_num_i;
  logic [LW-1:0] base_lvl_i, load_lvl_i;
  logic          load_lvl_en_o, base_lvl_en_o;
  logic [LW-1:0] load_lvl_o, base_lvl_o;
  logic          start_decision_o, done_decision_i, all_assigned_i;
  logic [LW-1:0] cur_lvl_i;
  logic          apply_imply_o, done_imply_i, find_conflict_i;
  logic          apply_analyze_o, add_learntc_en_i, done_analyze_i;
  logic [BW-1:0] bkt_bin_i;
  logic [LW-1:0] bkt_lvl_i;
  logic          apply_bkt_cur_bin_o, done_bkt_cur_bin_i;
  logic          busy_o, done_o;
  logic [1:0]    result_o;
  logic [BW-1:0] bkt_bin_o;
  logic [LW-1:0] bkt_lvl_o;
  logic [CW-1:0] num_decisions_o, num_conflicts_o, num_learnt_o;

  int checks = 0;
  int errors = 0;
  int cnt_analyze = 0;
  int cnt_bkt = 0;
  int cnt_done = 0;

  sat_engine_ctrl #(
    .WIDTH_LVL(LW), .WIDTH_BIN_ID(BW), .WIDTH_CNT(CW), .MAX_CONFLICTS(MAXC)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .cur_bin_num_i(cur_bin_num_i),
    .base_lvl_i(base_lvl_i), .load_lvl_i(load_lvl_i),
    .load_lvl_en_o(load_lvl_en_o), .base_lvl_en_o(base_lvl_en_o),
    .load_lvl_o(load_lvl_o), .base_lvl_o(base_lvl_o),
    .start_decision_o(start_decision_o), .done_decision_i(done_decision_i),
    .all_assigned_i(all_assigned_i), .cur_lvl_i(cur_lvl_i),
    .apply_imply_o(apply_imply_o), .done_imply_i(done_imply_i),
    .find_conflict_i(find_conflict_i), .apply_analyze_o(apply_analyze_o),
    .add_learntc_en_i(add_learntc_en_i), .done_analyze_i(done_analyze_i),
    .bkt_bin_i(bkt_bin_i), .bkt_lvl_i(bkt_lvl_i),
    .apply_bkt_cur_bin_o(apply_bkt_cur_bin_o), .done_bkt_cur_bin_i(done_bkt_cur_bin_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
    .bkt_bin_o(bkt_bin_o), .bkt_lvl_o(bkt_lvl_o),
    .num_decisions_o(num_decisions_o), .num_conflicts_o(num_conflicts_o),
    .num_learnt_o(num_learnt_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (apply_analyze_o === 1'b1)     cnt_analyze++;
    if (apply_bkt_cur_bin_o === 1'b1) cnt_bkt++;
    if (done_o === 1'b1)              cnt_done++;
  end

  function automatic logic out_sel(input int sel);
    case (sel)
      0:       return apply_imply_o;
      1:       return start_decision_o;
      2:       return apply_analyze_o;
      3:       return apply_bkt_cur_bin_o;
      default: return done_o;
    endcase
  endfunction

  function automatic logic [200:0] all_outs();
    return {load_lvl_en_o, base_lvl_en_o, load_lvl_o, base_lvl_o, start_decision_o,
            apply_imply_o, apply_analyze_o, apply_bkt_cur_bin_o, busy_o, done_o,
            result_o, bkt_bin_o, bkt_lvl_o, num_decisions_o, num_conflicts_o, num_learnt_o};
  endfunction

  task automatic clear_inputs;
    start_i = 0; cur_bin_num_i = '0; base_lvl_i = '0; load_lvl_i = '0;
    done_decision_i = 0; all_assigned_i = 0; cur_lvl_i = '0;
    done_imply_i = 0; find_conflict_i = 0; add_learntc_en_i = 0;
    done_analyze_i = 0; bkt_bin_i = '0; bkt_lvl_i = '0; done_bkt_cur_bin_i = 0;
  endtask

  task automatic wait_out(input int sel, input string name);
    int n = 0;
    while (out_sel(sel) !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_sel(sel) !== 1'b1) begin
      errors++;
      $display("FAIL wait_%s: got 0 after %0d cycles, expected 1", name, n);
    end
  endtask

  task automatic do_start(input logic [BW-1:0] bin, input logic [LW-1:0] base,
                          input logic [LW-1:0] load);
    start_i = 1; cur_bin_num_i = bin; base_lvl_i = base; load_lvl_i = load;
    @(negedge clk);
    start_i = 0;
  endtask

  task automatic imply_resp(input bit conf, input logic [LW-1:0] lvl, input int lat);
    wait_out(0, "imply");
    repeat (lat) @(negedge clk);
    done_imply_i = 1; find_conflict_i = conf; cur_lvl_i = lvl;
    @(negedge clk);
    done_imply_i = 0; find_conflict_i = 0;
  endtask

  task automatic decide_resp(input bit all, input int lat);
    wait_out(1, "decide");
    @(negedge clk);
    repeat (lat) @(negedge clk);
    done_decision_i = 1; all_assigned_i = all;
    @(negedge clk);
    done_decision_i = 0; all_assigned_i = 0;
  endtask

  task automatic analyze_resp(input int nl, input bit lod, input logic [BW-1:0] bb,
                              input logic [LW-1:0] bl);
    wait_out(2, "analyze");
    for (int i = 0; i < nl; i++) begin
      add_learntc_en_i = 1;
      @(negedge clk);
      add_learntc_en_i = 0;
      @(negedge clk);
    end
    done_analyze_i = 1; add_learntc_en_i = lod; bkt_bin_i = bb; bkt_lvl_i = bl;
    @(negedge clk);
    done_analyze_i = 0; add_learntc_en_i = 0;
  endtask

  task automatic bkt_resp(input int lat);
    wait_out(3, "bkt");
    repeat (lat) @(negedge clk);
    done_bkt_cur_bin_i = 1;
    @(negedge clk);
    done_bkt_cur_bin_i = 0;
  endtask

  task automatic test_reset;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected 0", all_outs());
    end
  endtask

  task automatic test_sat_latency;
    do_start(10'd1, 16'd0, 16'd0);
    checks++;
    if ({load_lvl_en_o, base_lvl_en_o, apply_imply_o} !== 3'b110) begin
      errors++;
      $display("FAIL sat_load_strobe: got %b, expected 110", {load_lvl_en_o, base_lvl_en_o, apply_imply_o});
    end
    @(negedge clk);
    checks++;
    if ({load_lvl_en_o, apply_imply_o} !== 2'b01) begin
      errors++;
      $display("FAIL sat_imply_latency: got %b, expected 01", {load_lvl_en_o, apply_imply_o});
    end
    imply_resp(0, 16'd0, 0);
    decide_resp(1, 1);
    wait_out(4, "done");
    checks++;
    if ({result_o, num_decisions_o, num_conflicts_o} !== {2'd0, 16'd0, 16'd0}) begin
      errors++;
      $display("FAIL sat_result: got res=%0d dec=%0d conf=%0d, expected 0 0 0",
               result_o, num_decisions_o, num_conflicts_o);
    end
    @(negedge clk);
    checks++;
    if ({done_o, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL sat_done_pulse: got %b, expected 00", {done_o, busy_o});
    end
  endtask

  task automatic test_unsat;
    int a0 = cnt_analyze;
    do_start(10'd4, 16'd0, 16'd0);
    imply_resp(1, 16'd0, 1);
    wait_out(4, "done");
    checks++;
    if ({result_o, num_conflicts_o} !== {2'd1, 16'd1} || cnt_analyze != a0) begin
      errors++;
      $display("FAIL unsat_result: got res=%0d conf=%0d analyze_cycles=%0d, expected 1 1 0",
               result_o, num_conflicts_o, cnt_analyze - a0);
    end
    @(negedge clk);
  endtask

  task automatic test_local_bkt;
    do_start(10'd5, 16'd1, 16'd3);
    imply_resp(1, 16'd3, 0);
    analyze_resp(2, 0, 10'd5, 16'd1);
    checks++;
    if ({apply_analyze_o, apply_bkt_cur_bin_o, apply_imply_o} !== 3'b000) begin
      errors++;
      $display("FAIL local_ana_rel: got %b, expected 000",
               {apply_analyze_o, apply_bkt_cur_bin_o, apply_imply_o});
    end
    @(negedge clk);
    checks++;
    if ({apply_analyze_o, apply_bkt_cur_bin_o, bkt_bin_o, bkt_lvl_o} !== {2'b01, 10'd5, 16'd1}) begin
      errors++;
      $display("FAIL local_bkt_req: got ana=%b bkt=%b bin=%0d lvl=%0d, expected 0 1 5 1",
               apply_analyze_o, apply_bkt_cur_bin_o, bkt_bin_o, bkt_lvl_o);
    end
    done_bkt_cur_bin_i = 1;
    @(negedge clk);
    done_bkt_cur_bin_i = 0;
    checks++;
    if ({apply_bkt_cur_bin_o, apply_imply_o} !== 2'b01) begin
      errors++;
      $display("FAIL local_back_to_imply: got %b, expected 01", {apply_bkt_cur_bin_o, apply_imply_o});
    end
    imply_resp(0, 16'd1, 0);
    decide_resp(1, 0);
    wait_out(4, "done");
    checks++;
    if ({result_o, num_learnt_o, num_conflicts_o} !== {2'd0, 16'd2, 16'd1}) begin
      errors++;
      $display("FAIL local_stats: got res=%0d learnt=%0d conf=%0d, expected 0 2 1",
               result_o, num_learnt_o, num_conflicts_o);
    end
    @(negedge clk);
  endtask

  task automatic test_bkt_other;
    int b0 = cnt_bkt;
    do_start(10'd5, 16'd1, 16'd3);
    imply_resp(1, 16'd3, 1);
    wait_out(2, "analyze");
    do_start(10'd9, 16'd0, 16'd7);
    analyze_resp(1, 1, 10'd2, 16'd4);
    wait_out(4, "done");
    checks++;
    if ({result_o, bkt_bin_o, bkt_lvl_o, num_learnt_o} !== {2'd2, 10'd2, 16'd4, 16'd2}) begin
      errors++;
      $display("FAIL other_result: got res=%0d bin=%0d lvl=%0d learnt=%0d, expected 2 2 4 2",
               result_o, bkt_bin_o, bkt_lvl_o, num_learnt_o);
    end
    checks++;
    if ({load_lvl_o, base_lvl_o} !== {16'd3, 16'd1} || cnt_bkt != b0) begin
      errors++;
      $display("FAIL other_no_restart: got load=%0d base=%0d bkt_cycles=%0d, expected 3 1 0",
               load_lvl_o, base_lvl_o, cnt_bkt - b0);
    end
    @(negedge clk);
  endtask

  task automatic test_abort;
    do_start(10'd3, 16'd0, 16'd0);
    for (int i = 0; i < MAXC; i++) begin
      imply_resp(1, 16'd2, 0);
      analyze_resp(0, 0, 10'd3, 16'd1);
      bkt_resp(0);
    end
    imply_resp(1, 16'd2, 0);
    wait_out(4, "done");
    checks++;
    if ({result_o, num_conflicts_o, num_learnt_o} !== {2'd3, 16'(MAXC + 1), 16'd0}) begin
      errors++;
      $display("FAIL abort_result: got res=%0d conf=%0d learnt=%0d, expected 3 %0d 0",
               result_o, num_conflicts_o, num_learnt_o, MAXC + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int d0;
    do_start(10'd5, 16'd1, 16'd3);
    imply_resp(1, 16'd3, 0);
    wait_out(2, "analyze");
    add_learntc_en_i = 1;
    @(negedge clk);
    add_learntc_en_i = 0;
    d0 = cnt_done;
    #2 rst = 1;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h, expected 0", all_outs());
    end
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (cnt_done != d0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_done: got done_cycles=%0d busy=%b, expected 0 0", cnt_done - d0, busy_o);
    end
    do_start(10'd7, 16'd0, 16'd2);
    checks++;
    if ({num_decisions_o, num_conflicts_o, num_learnt_o, load_lvl_o} !== {48'd0, 16'd2}) begin
      errors++;
      $display("FAIL midreset_restart_clear: got dec=%0d conf=%0d learnt=%0d load=%0d, expected 0 0 0 2",
               num_decisions_o, num_conflicts_o, num_learnt_o, load_lvl_o);
    end
    imply_resp(0, 16'd2, 0);
    decide_resp(0, 0);
    imply_resp(0, 16'd3, 1);
    decide_resp(1, 0);
    wait_out(4, "done");
    checks++;
    if ({result_o, num_decisions_o} !== {2'd0, 16'd1}) begin
      errors++;
      $display("FAIL midreset_rerun: got res=%0d dec=%0d, expected 0 1", result_o, num_decisions_o);
    end
    @(negedge clk);
  endtask

  task automatic test_random_runs;
    for (int r = 0; r < 25; r++) begin
      logic [BW-1:0] bin, bb, eb;
      logic [LW-1:0] base, lvl, bl, el;
      logic [1:0]    exp_res;
      int            conf, dec, learnt, steps, nl;
      bit            fin, c, all, lod, local_b;
      bin = BW'($urandom % 1024);
      base = LW'($urandom % 3);
      conf = 0; dec = 0; learnt = 0; steps = 0; fin = 0;
      eb = '0; el = '0; exp_res = 2'd0;
      do_start(bin, base, LW'($urandom % 8));
      while (!fin) begin
        steps++;
        c = 1'($urandom % 2);
        lvl = LW'($urandom % 6);
        imply_resp(c, lvl, int'($urandom % 3));
        if (!c) begin
          all = (steps >= 10) || ($urandom % 4 == 0);
          decide_resp(all, int'($urandom % 3));
          if (all) begin exp_res = 2'd0; fin = 1; end
          else dec++;
        end else begin
          conf++;
          if (base == 0 && lvl <= base) begin
            exp_res = 2'd1; fin = 1;
          end else if (conf - 1 >= MAXC) begin
            exp_res = 2'd3; fin = 1;
          end else begin
            nl = int'($urandom % 3);
            lod = 1'($urandom % 2);
            learnt += nl + int'(lod);
            local_b = ($urandom % 4) != 0;
            bb = local_b ? bin : bin + BW'(1 + $urandom % 7);
            bl = LW'($urandom);
            analyze_resp(nl, lod, bb, bl);
            eb = bb; el = bl;
            checks++;
            if ({apply_analyze_o, apply_bkt_cur_bin_o} !== 2'b00) begin
              errors++;
              $display("FAIL rand%0d_ana_rel: got %b, expected 00", r,
                       {apply_analyze_o, apply_bkt_cur_bin_o});
            end
            if (local_b) bkt_resp(int'($urandom % 2));
            else begin exp_res = 2'd2; fin = 1; end
          end
        end
      end
      wait_out(4, "done");
      checks++;
      if ({result_o, num_decisions_o, num_conflicts_o, num_learnt_o} !==
          {exp_res, CW'(dec), CW'(conf), CW'(learnt)}) begin
        errors++;
        $display("FAIL rand%0d_stats: got res=%0d dec=%0d conf=%0d learnt=%0d, expected %0d %0d %0d %0d",
                 r, result_o, num_decisions_o, num_conflicts_o, num_learnt_o,
                 exp_res, dec, conf, learnt);
      end
      checks++;
      if ({bkt_bin_o, bkt_lvl_o} !== {eb, el}) begin
        errors++;
        $display("FAIL rand%0d_bkt_target: got %0d/%0d, expected %0d/%0d", r,
                 bkt_bin_o, bkt_lvl_o, eb, el);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    repeat (3) @(negedge clk);
    test_reset();
    rst = 0;
    @(negedge clk);
    test_reset();
    test_sat_latency();
    test_unsat();
    test_local_bkt();
    test_bkt_other();
    test_abort();
    test_reset_mid_run();
    test_random_runs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
